// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller and its load-use comparator.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam int REG_W_DEF = 5;
  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Pure combinational load-use detector, also reusable by the forwarding unit.
// Zero latency, no state, no backpressure.
module hazard_loaduse_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_hazard
);

  logic w_dst_live;
  logic w_rs_match;
  logic w_rt_match;

  // A load into the zero register never produces a value worth waiting for.
  assign w_dst_live = (i_ex_rt != REG_W'(ZERO_REG));
  assign w_rs_match = (i_ex_rt == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
  assign o_hazard   = i_ex_memread && w_dst_live && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, memory-wait freeze, branch flush.
// Control outputs are combinational from state + inputs; state/counters update on clk_i.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              r_state;
  logic                r_pend_flush;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                r_err;

  logic w_miss;
  logic w_loaduse;
  logic w_pc_hold;
  logic w_ifid_hold;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_exmem_hold;

  assign w_miss = mem_req_i && !mem_ack_i;

  hazard_loaduse_cmp #(.REG_W(REG_W)) u_lu_cmp (
    .i_ex_memread (ex_memread_i),
    .i_ex_rt      (ex_rt_i),
    .i_id_rs      (id_rs_i),
    .i_id_rt      (id_rt_i),
    .i_id_uses_rt (id_uses_rt_i),
    .o_hazard     (w_loaduse)
  );

  always_comb begin
    w_pc_hold     = 1'b0;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_hold  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_miss) begin
          w_pc_hold    = 1'b1;
          w_ifid_hold  = 1'b1;
          w_exmem_hold = 1'b1;
        end else if (w_loaduse) begin
          // Branch outcome from stale operands is dropped here.
          w_pc_hold     = 1'b1;
          w_ifid_hold   = 1'b1;
          w_idex_bubble = 1'b1;
        end else begin
          w_ifid_flush = r_pend_flush || branch_taken_i;
        end
      end
      ST_MEM_WAIT: begin
        w_pc_hold    = 1'b1;
        w_ifid_hold  = 1'b1;
        w_exmem_hold = 1'b1;
      end
      default: begin
        w_pc_hold     = 1'b1;
        w_ifid_hold   = 1'b1;
        w_idex_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_pend_flush <= 1'b0;
      r_wait_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_pc_hold && (r_state != ST_IDLE) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (start_i) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_miss) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
            if (branch_taken_i) r_pend_flush <= 1'b1;
          end else if (!w_loaduse) begin
            r_pend_flush <= 1'b0;
          end
        end
        ST_MEM_WAIT: begin
          // ID is frozen here, so a taken branch stays valid until released.
          if (branch_taken_i) r_pend_flush <= 1'b1;
          if (mem_ack_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            r_err      <= 1'b1;
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pc_hold_o     = w_pc_hold;
  assign ifid_hold_o   = w_ifid_hold;
  assign ifid_flush_o  = w_ifid_flush;
  assign idex_bubble_o = w_idex_bubble;
  assign exmem_hold_o  = w_exmem_hold;
  assign stall_cnt_o   = r_stall_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT shortened to 4.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_uses_rt_i;
  logic        ex_memread_i;
  logic [4:0]  ex_rt_i;
  logic        branch_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        pc_hold_o;
  logic        ifid_hold_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        exmem_hold_o;
  logic [31:0] stall_cnt_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.REG_W(5), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .pc_hold_o      (pc_hold_o),
    .ifid_hold_o    (ifid_hold_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .exmem_hold_o   (exmem_hold_o),
    .stall_cnt_o    (stall_cnt_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Move to the next cycle: past the edge, inputs may then be driven.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 0; id_rs_i = 0; id_rt_i = 0; id_uses_rt_i = 0;
    ex_memread_i = 0; ex_rt_i = 0; branch_taken_i = 0;
    mem_req_i = 0; mem_ack_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (pc_hold_o !== 1'b1 || stall_cnt_o !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: pc_hold=%b stall=%0d, want 1 / 0", i, pc_hold_o, stall_cnt_o);
      end
      tick();
    end
    #1;
    n_checks++;
    if (ifid_hold_o !== 1'b1 || idex_bubble_o !== 1'b1 || exmem_hold_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: ifid_hold=%b bubble=%b exmem=%b err=%b, want 1 1 0 0",
               ifid_hold_o, idex_bubble_o, exmem_hold_o, err_o);
    end
    start_i = 1;
    tick();
    start_i = 0;
    #1;
    n_checks++;
    if (pc_hold_o !== 1'b0 || idex_bubble_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL start_run: pc_hold=%b bubble=%b stall=%0d, want 0 0 0", pc_hold_o, idex_bubble_o, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_loaduse();
    ex_memread_i = 1; ex_rt_i = 8; id_rs_i = 8;
    #1;
    n_checks++;
    if (pc_hold_o !== 1'b1 || ifid_hold_o !== 1'b1 || idex_bubble_o !== 1'b1 || exmem_hold_o !== 1'b0) begin
      n_fail++;
      $display("FAIL loaduse_rs: pc=%b ifid=%b bubble=%b exmem=%b, want 1 1 1 0",
               pc_hold_o, ifid_hold_o, idex_bubble_o, exmem_hold_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (pc_hold_o !== 1'b0 || idex_bubble_o !== 1'b0 || stall_cnt_o !== 32'd1) begin
      n_fail++;
      $display("FAIL loaduse_release: pc=%b bubble=%b stall=%0d, want 0 0 1", pc_hold_o, idex_bubble_o, stall_cnt_o);
    end
    tick();
    ex_memread_i = 1; ex_rt_i = 0; id_rs_i = 0;
    #1;
    n_checks++;
    if (pc_hold_o !== 1'b0 || idex_bubble_o !== 1'b0) begin
      n_fail++;
      $display("FAIL loaduse_r0: pc=%b bubble=%b, want 0 0", pc_hold_o, idex_bubble_o);
    end
    tick();
    ex_rt_i = 8; id_rs_i = 3; id_rt_i = 8; id_uses_rt_i = 0;
    #1;
    n_checks++;
    if (pc_hold_o !== 1'b0 || idex_bubble_o !== 1'b0) begin
      n_fail++;
      $display("FAIL loaduse_rt_unused: pc=%b bubble=%b, want 0 0", pc_hold_o, idex_bubble_o);
    end
    tick();
    id_uses_rt_i = 1;
    #1;
    n_checks++;
    if (pc_hold_o !== 1'b1 || idex_bubble_o !== 1'b1) begin
      n_fail++;
      $display("FAIL loaduse_rt_used: pc=%b bubble=%b, want 1 1", pc_hold_o, idex_bubble_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cnt_o !== 32'd2) begin
      n_fail++;
      $display("FAIL loaduse_stallcnt: got %0d want 2", stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_mem_stall();
    int pc_ones = 0;
    int ex_ones = 0;
    mem_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = (i == 3);
      #1;
      if (pc_hold_o === 1'b1) pc_ones++;
      if (exmem_hold_o === 1'b1) ex_ones++;
      n_checks++;
      if (idex_bubble_o !== 1'b0 || ifid_flush_o !== 1'b0 || ifid_hold_o !== 1'b1) begin
        n_fail++;
        $display("FAIL mem_wait_outs cyc%0d: bubble=%b flush=%b ifid_hold=%b, want 0 0 1",
                 i, idex_bubble_o, ifid_flush_o, ifid_hold_o);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++;
    if (pc_ones != 4 || ex_ones != 4 || pc_hold_o !== 1'b0 || exmem_hold_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_stall_len: pc_ones=%0d exmem_ones=%0d after pc=%b exmem=%b, want 4 4 0 0",
               pc_ones, ex_ones, pc_hold_o, exmem_hold_o);
    end
    n_checks++;
    if (stall_cnt_o !== 32'd6) begin
      n_fail++;
      $display("FAIL mem_stallcnt: got %0d want 6", stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_branch_pending();
    branch_taken_i = 1;
    #1;
    n_checks++;
    if (ifid_flush_o !== 1'b1 || pc_hold_o !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_run: flush=%b pc=%b, want 1 0", ifid_flush_o, pc_hold_o);
    end
    tick();
    idle_inputs();
    mem_req_i = 1;
    tick();
    tick();
    branch_taken_i = 1;
    #1;
    n_checks++;
    if (ifid_flush_o !== 1'b0 || pc_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_in_wait: flush=%b pc=%b, want 0 1", ifid_flush_o, pc_hold_o);
    end
    tick();
    branch_taken_i = 0;
    tick();
    mem_ack_i = 1;
    #1;
    n_checks++;
    if (ifid_flush_o !== 1'b0 || pc_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_ack_cycle: flush=%b pc=%b, want 0 1", ifid_flush_o, pc_hold_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (ifid_flush_o !== 1'b1 || pc_hold_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_flush_apply: flush=%b pc=%b err=%b, want 1 0 0", ifid_flush_o, pc_hold_o, err_o);
    end
    tick();
    #1;
    n_checks++;
    if (ifid_flush_o !== 1'b0 || stall_cnt_o !== 32'd11) begin
      n_fail++;
      $display("FAIL pend_flush_once: flush=%b stall=%0d, want 0 11", ifid_flush_o, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_loaduse_branch();
    ex_memread_i = 1; ex_rt_i = 5; id_rs_i = 5; branch_taken_i = 1;
    #1;
    n_checks++;
    if (ifid_flush_o !== 1'b0 || idex_bubble_o !== 1'b1 || pc_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL loaduse_branch: flush=%b bubble=%b pc=%b, want 0 1 1", ifid_flush_o, idex_bubble_o, pc_hold_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cnt_o !== 32'd12) begin
      n_fail++;
      $display("FAIL loaduse_branch_cnt: got %0d want 12", stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    mem_req_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (err_o !== 1'b0 || pc_hold_o !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_wait cyc%0d: err=%b pc=%b, want 0 1", i, err_o, pc_hold_o);
      end
      tick();
    end
    mem_req_i = 0;
    #1;
    n_checks++;
    if (err_o !== 1'b1 || pc_hold_o !== 1'b0 || stall_cnt_o !== 32'd17) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b pc=%b stall=%0d, want 1 0 17", err_o, pc_hold_o, stall_cnt_o);
    end
    tick();
    tick();
    #1;
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b want 1", err_o);
    end
    rst_i = 1;
    tick();
    rst_i = 0;
    #1;
    n_checks++;
    if (err_o !== 1'b0 || stall_cnt_o !== 32'd0 || pc_hold_o !== 1'b1 || idex_bubble_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_reset: err=%b stall=%0d pc=%b bubble=%b, want 0 0 1 1",
               err_o, stall_cnt_o, pc_hold_o, idex_bubble_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    start_i = 1;
    tick();
    start_i = 0;
    mem_req_i = 1;
    tick();
    branch_taken_i = 1;
    tick();
    idle_inputs();
    rst_i = 1;
    tick();
    rst_i = 0;
    #1;
    n_checks++;
    if (pc_hold_o !== 1'b1 || exmem_hold_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_wait: pc=%b exmem=%b stall=%0d, want 1 0 0", pc_hold_o, exmem_hold_o, stall_cnt_o);
    end
    start_i = 1;
    tick();
    start_i = 0;
    #1;
    n_checks++;
    if (ifid_flush_o !== 1'b0 || pc_hold_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_dropped: flush=%b pc=%b, want 0 0", ifid_flush_o, pc_hold_o);
    end
    tick();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    #1;
    test_reset();
    test_loaduse();
    test_mem_stall();
    test_branch_pending();
    test_loaduse_branch();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
